wishbone_bus_arbiter_2m: RTL and testbench
==========================================

# wishbone_bus_arbiter_2m

Two-master, one-slave Wishbone arbiter that shares the single external Wishbone slave port between the data-bus bridge (master 0) and the instruction-bus bridge (master 1) of the OpenMIPS core. Grants are registered: one master owns the slave port for one complete single-beat transfer, and the arbiter routes `ack` back only to that master. It sits between the two RAM-to-Wishbone bridges and the SoC bus.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SEL_WIDTH, 4, byte-select width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  data-bus master cycle/strobe/write
- m0_addr_i  in  ADDR_WIDTH  master 0 address
- m0_data_i  in  DATA_WIDTH  master 0 write data
- m0_sel_i  in  SEL_WIDTH  master 0 byte selects
- m0_data_o  out  DATA_WIDTH  read data to master 0
- m0_ack_o  out  1  acknowledge to master 0
- m1_cyc_i … m1_ack_o: same eight ports for the instruction-bus master
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_addr_o  out  ADDR_WIDTH  to slave
- s_data_o  out  DATA_WIDTH  to slave
- s_sel_o  out  SEL_WIDTH  to slave
- s_data_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave acknowledge
- m0_gnt_o, m1_gnt_o  out  1  current grant, for debug and performance counting

## Operation
- State machine with three states: ARB_IDLE, ARB_M0, ARB_M1.
- ARB_IDLE:
  - A master requests when `mX_cyc_i & mX_stb_i`.
  - Only one requester: go to that master's state.
  - Both request: winner set by the priority policy (see Configuration).
  - None: stay in ARB_IDLE.
- ARB_Mx:
  - The granted master's cyc, stb, we, addr, data and sel pass combinationally to the slave port.
  - `mX_ack_o = s_ack_i & mX_cyc_i`. The other master's ack is 0.
  - Go to ARB_IDLE on `s_ack_i` (transfer complete) or when the granted `mX_cyc_i` is 0 (abort or flush).
  - The non-granted master waits. Its cyc/stb are ignored, not queued.
- In ARB_IDLE all slave outputs are 0: cyc, stb, we, addr, data, sel.
- `m0_data_o = m1_data_o = s_data_i` unconditionally. Only the ack is gated.
- `mX_gnt_o = (state == ARB_Mx)`.
- Illegal state encoding returns to ARB_IDLE on the next clock.

## Timing
- Reset: state ARB_IDLE; all outputs 0; round-robin last-grant register = master 1, so master 0 wins the first tie.
- Reset asserted mid-transfer: immediately forces ARB_IDLE and drops s_cyc_o/s_stb_o (asynchronous).
- Grant latency: request sampled in ARB_IDLE at cycle N; slave sees stb at N+1. A request that appears in the same cycle as a release is not seen until the arbiter is back in ARB_IDLE.
- Zero-wait slave: ack at N+1, arbiter in ARB_IDLE at N+2. Minimum 2 cycles per transfer.
- Back-to-back transfers by the same master with no competitor: grant re-issued 1 cycle after that master re-asserts cyc in ARB_IDLE.
- Wait-state slave: grant held, with no limit, until ack or until the granted cyc drops.
- `s_ack_i` while in ARB_IDLE is ignored; no master ack is generated.
- The registered grant guarantees the slave never sees a strobe during the bridge's own IDLE-cycle request, so a slave ack can never be duplicated.

## Configuration
- `WB_ARB_RR_EN` defined:
  - On a tie, grant the master that was not granted last.
  - The last-grant register updates on every ARB_IDLE→ARB_Mx transition.
- Not defined: fixed priority, master 0 (data bus) always wins ties. The last-grant register is not built.

## Structure
- State encodings ARB_IDLE = 2'b00, ARB_M0 = 2'b01, ARB_M1 = 2'b10 live in the shared defines header, next to `RstEnable` and `ChipEnable`.
- One sub-module, `wb_arb_pick`:
  - Combinational.
  - Inputs: req[1:0], last-grant.
  - Outputs: one-hot winner.
  - Contains the `WB_ARB_RR_EN` policy.
- The top level holds the state register, the slave-side mux and the ack routing.

## Test plan
- Reset: rst_n=0 with m0 requesting → s_cyc_o=0, m0_ack_o=0, m0_gnt_o=0; after release, grant in cycle 2.
- Single master 0 write: addr 0x0000_0010, data 0xA5A5_5A5A, sel 4'hF, zero-wait slave → slave sees exactly one stb cycle with those values; m0_ack_o pulses once; m1_ack_o stays 0.
- Simultaneous request with 3 wait states: m1 read addr 0x0000_0100, slave returns 0x1234_5678 with a 3-wait ack → grant held 4 cycles; m1 receives the data with ack; m0 granted afterwards.
- Tie, repeated 4 times with both masters always requesting:
  - `WB_ARB_RR_EN` off → grant order m0,m0,m0,m0 (m1 starves).
  - `WB_ARB_RR_EN` on → m0,m1,m0,m1.
- Abort: m0 drops cyc during a wait state → next cycle ARB_IDLE; the late s_ack_i is ignored (no ack to either master); a pending m1 request is then granted.
- Asynchronous reset mid-transfer: rst_n pulsed low during ARB_M1 → s_cyc_o falls in the same cycle; state returns to ARB_IDLE.

Source files
------------

// File: rtl/wishbone_bus_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: reset/enable levels and
// arbiter state encodings.
package wishbone_bus_arbiter_2m_pkg;

  localparam logic RstEnable  = 1'b0;
  localparam logic ChipEnable = 1'b1;

  typedef enum logic [1:0] {
    ArbIdle = 2'b00,
    ArbM0   = 2'b01,
    ArbM1   = 2'b10
  } arb_state_e;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection for the two-master arbiter.
// WB_ARB_RR_EN selects round-robin tie-breaking; otherwise master 0 wins every tie.
module wb_arb_pick (
  input  logic [1:0] req,
`ifdef WB_ARB_RR_EN
  input  logic       last_gnt,
`endif
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) begin
`ifdef WB_ARB_RR_EN
      // last_gnt = 1 means master 1 was granted last, so master 0 goes next
      win = last_gnt ? 2'b01 : 2'b10;
`else
      win = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/wishbone_bus_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with a registered single-transfer grant.
// Define WB_ARB_RR_EN for round-robin ties; default is fixed priority to master 0.
module wishbone_bus_arbiter_2m
  import wishbone_bus_arbiter_2m_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic                  m0_gnt_o,
  output logic                  m1_gnt_o
);

  arb_state_e state_q;
  logic [1:0] req;
  logic [1:0] win;

  assign req = {(m1_cyc_i & m1_stb_i) == ChipEnable, (m0_cyc_i & m0_stb_i) == ChipEnable};

`ifdef WB_ARB_RR_EN
  logic last_gnt_q;

  wb_arb_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .win      (win)
  );
`else
  wb_arb_pick u_pick (
    .req (req),
    .win (win)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      state_q <= ArbIdle;
`ifdef WB_ARB_RR_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        ArbIdle: begin
          if (win[0]) begin
            state_q <= ArbM0;
`ifdef WB_ARB_RR_EN
            last_gnt_q <= 1'b0;
`endif
          end else if (win[1]) begin
            state_q <= ArbM1;
`ifdef WB_ARB_RR_EN
            last_gnt_q <= 1'b1;
`endif
          end
        end
        // Release on completion or when the owner abandons its cycle
        ArbM0: if (s_ack_i || !m0_cyc_i) state_q <= ArbIdle;
        ArbM1: if (s_ack_i || !m1_cyc_i) state_q <= ArbIdle;
        default: state_q <= ArbIdle;
      endcase
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state_q)
      ArbM0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        s_sel_o  = m0_sel_i;
        m0_ack_o = s_ack_i & m0_cyc_i;
      end
      ArbM1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        s_sel_o  = m1_sel_i;
        m1_ack_o = s_ack_i & m1_cyc_i;
      end
      default: ;
    endcase
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign m0_gnt_o  = (state_q == ArbM0);
  assign m1_gnt_o  = (state_q == ArbM1);

endmodule

// File: tb/tb_wishbone_bus_arbiter_2m.sv
// Scoreboard bench for wishbone_bus_arbiter_2m: directed master transactions, a wait-state
// slave model, and a monitor that checks every completed slave transfer against a queue.
module tb_wishbone_bus_arbiter_2m;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } txn_t;

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int unsigned hold;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_data_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_data_o;
  logic        m0_ack_o;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m1_addr_i = '0, m1_data_i = '0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_data_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_i = '0;
  logic        s_ack_i;
  logic        m0_gnt_o, m1_gnt_o;

  logic        slave_ack = 1'b0;
  logic        force_ack = 1'b0;
  int unsigned slave_waits = 0;
  logic [31:0] slave_rdata = '0;
  int unsigned stb_cnt = 0;
  int unsigned stb_cycles = 0;
  logic [1:0]  abort_req = 2'b00;

  txn_t mq0[$];
  txn_t mq1[$];
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign s_ack_i = slave_ack | force_ack;

  wishbone_bus_arbiter_2m #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .SEL_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_cyc_i  (m0_cyc_i),
    .m0_stb_i  (m0_stb_i),
    .m0_we_i   (m0_we_i),
    .m0_addr_i (m0_addr_i),
    .m0_data_i (m0_data_i),
    .m0_sel_i  (m0_sel_i),
    .m0_data_o (m0_data_o),
    .m0_ack_o  (m0_ack_o),
    .m1_cyc_i  (m1_cyc_i),
    .m1_stb_i  (m1_stb_i),
    .m1_we_i   (m1_we_i),
    .m1_addr_i (m1_addr_i),
    .m1_data_i (m1_data_i),
    .m1_sel_i  (m1_sel_i),
    .m1_data_o (m1_data_o),
    .m1_ack_o  (m1_ack_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_data_o  (s_data_o),
    .s_sel_o   (s_sel_o),
    .s_data_i  (s_data_i),
    .s_ack_i   (s_ack_i),
    .m0_gnt_o  (m0_gnt_o),
    .m1_gnt_o  (m1_gnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input bit m, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.sel = s;
    if (m) mq1.push_back(t);
    else mq0.push_back(t);
  endtask

  task automatic expect_xfer(input bit m, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input logic [31:0] rd, input int unsigned hold);
    exp_t e;
    e.mst = m; e.we = we; e.addr = a; e.wdata = d; e.sel = s; e.rdata = rd; e.hold = hold;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #2;
      if (mq0.size() == 0 && mq1.size() == 0 && !s_cyc_o) done = 1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_gnt(input string name, input bit m, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #2;
      if ((m ? m1_gnt_o : m0_gnt_o) == 1'b1) done = 1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  // Slave: acks on the (slave_waits+1)-th strobe cycle
  initial forever begin
    @(posedge clk); #1;
    if (s_cyc_o && s_stb_o) begin
      slave_ack = (stb_cnt == slave_waits);
      stb_cnt++;
    end else begin
      slave_ack = 1'b0;
      stb_cnt = 0;
    end
    s_data_i = slave_rdata;
  end

  // Monitor first, then the master models react to what was sampled
  always @(negedge clk) begin
    exp_t e;
    if (s_cyc_o && s_stb_o) stb_cycles++;
    if (s_cyc_o && s_stb_o && s_ack_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer_addr", s_addr_o, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_gnt_m1", 32'(m1_gnt_o), 32'(e.mst));
        chk("xfer_ack_owner", 32'(e.mst ? m1_ack_o : m0_ack_o), 32'd1);
        chk("xfer_ack_other", 32'(e.mst ? m0_ack_o : m1_ack_o), 32'd0);
        chk("xfer_we", 32'(s_we_o), 32'(e.we));
        chk("xfer_addr", s_addr_o, e.addr);
        chk("xfer_wdata", s_data_o, e.wdata);
        chk("xfer_sel", 32'(s_sel_o), 32'(e.sel));
        chk("xfer_rdata", e.mst ? m1_data_o : m0_data_o, e.rdata);
        chk("xfer_hold", stb_cycles, e.hold);
      end
    end else if (s_ack_i) begin
      chk("idle_ack_m0", 32'(m0_ack_o), 32'd0);
      chk("idle_ack_m1", 32'(m1_ack_o), 32'd0);
    end
    if (!(s_cyc_o && s_stb_o) || s_ack_i) stb_cycles = 0;

    if (m0_cyc_i && (m0_ack_o || abort_req[0])) begin
      void'(mq0.pop_front());
      abort_req[0] = 1'b0;
    end
    if (m1_cyc_i && (m1_ack_o || abort_req[1])) begin
      void'(mq1.pop_front());
      abort_req[1] = 1'b0;
    end
    if (mq0.size() > 0) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = mq0[0].we;
      m0_addr_i = mq0[0].addr; m0_data_i = mq0[0].wdata; m0_sel_i = mq0[0].sel;
    end else begin
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
      m0_addr_i = '0; m0_data_i = '0; m0_sel_i = '0;
    end
    if (mq1.size() > 0) begin
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = mq1[0].we;
      m1_addr_i = mq1[0].addr; m1_data_i = mq1[0].wdata; m1_sel_i = mq1[0].sel;
    end else begin
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
      m1_addr_i = '0; m1_data_i = '0; m1_sel_i = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with master 0 already requesting
    slave_waits = 0;
    slave_rdata = 32'hCAFE_0001;
    send(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);
    expect_xfer(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF, 32'hCAFE_0001, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_s_stb", 32'(s_stb_o), 32'd0);
    chk("rst_m0_ack", 32'(m0_ack_o), 32'd0);
    chk("rst_m0_gnt", 32'(m0_gnt_o), 32'd0);
    chk("rst_s_addr", s_addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("gnt_before_first_edge", 32'(m0_gnt_o), 32'd0);
    @(posedge clk); #2;
    chk("gnt_after_first_edge", 32'(m0_gnt_o), 32'd1);
    chk("stb_after_first_edge", 32'(s_stb_o), 32'd1);
    @(posedge clk); #2;
    chk("idle_two_cycles_after_req", 32'(m0_gnt_o), 32'd0);
    wait_done("single_write_done", 20);

    // m1 read with 3 wait states; m0 arrives while m1 holds the grant
    slave_waits = 3;
    slave_rdata = 32'h1234_5678;
    send(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    expect_xfer(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h1234_5678, 4);
    @(posedge clk);
    send(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h3);
    expect_xfer(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 4);
    @(posedge clk); #2;
    chk("hold_m1_gnt", 32'(m1_gnt_o), 32'd1);
    chk("hold_m0_waits", 32'(m0_gnt_o), 32'd0);
    wait_done("wait_state_done", 40);

    // Persistent tie from a fresh reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    slave_waits = 0;
    slave_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'hA00 + 32'(i), 4'hF);
      send(1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'h0, 4'hF);
    end
`ifdef WB_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      expect_xfer(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'hA00 + 32'(i), 4'hF, 32'h5555_AAAA, 1);
      expect_xfer(1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'h0, 4'hF, 32'h5555_AAAA, 1);
    end
`else
    for (int i = 0; i < 4; i++)
      expect_xfer(1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'hA00 + 32'(i), 4'hF, 32'h5555_AAAA, 1);
    for (int i = 0; i < 4; i++)
      expect_xfer(1'b1, 1'b0, 32'h300 + 32'(i * 4), 32'h0, 4'hF, 32'h5555_AAAA, 1);
`endif
    wait_done("tie_done", 60);

    // m0 aborts mid wait-state; a late ack must not reach anyone; m1 then gets the bus
    slave_waits = 5;
    slave_rdata = 32'h0F0F_F0F0;
    send(1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF);
    wait_gnt("abort_m0_gnt", 1'b0, 10);
    @(posedge clk);
    send(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    expect_xfer(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h0F0F_F0F0, 6);
    abort_req[0] = 1'b1;
    @(negedge clk); #1;
    chk("abort_s_cyc_drop", 32'(s_cyc_o), 32'd0);
    chk("abort_m0_gnt_still", 32'(m0_gnt_o), 32'd1);
    @(posedge clk); #2;
    chk("abort_idle_m0", 32'(m0_gnt_o), 32'd0);
    chk("abort_idle_m1", 32'(m1_gnt_o), 32'd0);
    force_ack = 1'b1;
    #1;
    chk("late_ack_m0", 32'(m0_ack_o), 32'd0);
    chk("late_ack_m1", 32'(m1_ack_o), 32'd0);
    #5;
    force_ack = 1'b0;
    @(posedge clk); #2;
    chk("abort_then_m1_gnt", 32'(m1_gnt_o), 32'd1);
    wait_done("abort_done", 40);

    // Asynchronous reset during an m1 transfer
    slave_waits = 5;
    send(1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
    wait_gnt("areset_m1_gnt", 1'b1, 10);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("areset_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("areset_s_stb", 32'(s_stb_o), 32'd0);
    chk("areset_m1_gnt", 32'(m1_gnt_o), 32'd0);
    abort_req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("post_reset_idle", 32'(m1_gnt_o | m0_gnt_o | s_cyc_o), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
